// File: rtl/vx_de_stall_ctrl.sv
// Hazard sequencer for the decode->execute pipeline register: merges load-use,
// branch-flush, clone and memory back-pressure into D/E stall controls.
module vx_de_stall_ctrl #(
    parameter int unsigned BRANCH_SHADOW = 2,
    parameter int unsigned CLONE_CYCLES  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_fwd_hazard,
    input  logic        in_branch_taken,
    input  logic        in_clone_req,
    input  logic        in_mem_busy,
    output logic        out_fwd_stall,
    output logic        out_branch_stall,
    output logic        out_clone_stall,
    output logic        out_freeze,
    output logic        out_clone_done,
    output logic [31:0] out_stall_count
);

    localparam int unsigned MAX_LOAD = ((BRANCH_SHADOW > CLONE_CYCLES) ? BRANCH_SHADOW : CLONE_CYCLES) - 1;
    localparam int unsigned CNT_W    = (MAX_LOAD > 0) ? $clog2(MAX_LOAD + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BRANCH = 2'd1,
        ST_CLONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               done_d;
    logic               bubble;

    // State, down-counter and done pulse register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            out_clone_done <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            out_clone_done <= done_d;
        end
    end

    // Next-state logic; a frozen cycle samples nothing and holds everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (!in_mem_busy) begin
            if (in_branch_taken) begin
                state_d = ST_BRANCH;
                cnt_d   = CNT_W'(BRANCH_SHADOW - 1);
            end else if (state_q == ST_IDLE) begin
                if (in_clone_req) begin
                    state_d = ST_CLONE;
                    cnt_d   = CNT_W'(CLONE_CYCLES - 1);
                end
            end else if (cnt_q == '0) begin
                state_d = ST_IDLE;
                done_d  = (state_q == ST_CLONE);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Output decode
    always_comb begin
        out_branch_stall = (state_q == ST_BRANCH);
        out_clone_stall  = (state_q == ST_CLONE);
        out_fwd_stall    = in_fwd_hazard & (state_q == ST_IDLE);
        out_freeze       = in_mem_busy;
        bubble           = out_fwd_stall | out_branch_stall | out_clone_stall;
    end

    // Wrapping bubble counter for performance CSRs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_stall_count <= '0;
        end else if (bubble && !in_mem_busy) begin
            out_stall_count <= out_stall_count + 32'd1;
        end
    end

endmodule
